// File: rtl/race_ctrl.sv
// Race controller: debounced start button, 3-2-1 countdown, lap counting on
// finish-line crossings and a saturating frame-based race timer.
module race_ctrl #(
  parameter int DEB_FRAMES  = 3,
  parameter int STEP_FRAMES = 60,
  parameter int LAPS        = 3
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        frame_tick,
  input  logic        finish_cross,
  output logic        start_req,
  output logic [1:0]  countdown,
  output logic        go,
  output logic [2:0]  lap,
  output logic [15:0] race_time,
  output logic        race_done,
  output logic        busy
);

  localparam int DEB_W  = (DEB_FRAMES  > 1) ? $clog2(DEB_FRAMES)  : 1;
  localparam int STEP_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_FRAMES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_FRAMES - 1);
  localparam logic [2:0]        LAP_LAST  = 3'(LAPS);
  localparam logic [15:0]       TIME_MAX  = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNTDOWN,
    ST_RACE,
    ST_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Button synchronizer and frame-rate debouncer
  // ---------------------------------------------------------------------------
  logic             btn_meta;
  logic             btn_sync;
  logic             deb_btn;
  logic             deb_prev;
  logic [DEB_W-1:0] deb_cnt;
  logic             press;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge pclk) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= btn_start;
      btn_sync <= btn_meta;
    end
  end

  // The stability counter only advances on frame ticks where the synchronized
  // level disagrees with the debounced one; any agreeing sample restarts it.
  always_ff @(posedge pclk) begin
    if (rst) begin
      deb_btn  <= 1'b0;
      deb_prev <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      deb_prev <= deb_btn;
      if (frame_tick) begin
        if (btn_sync == deb_btn) begin
          deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
          deb_btn <= btn_sync;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end
    end
  end

  assign press = deb_btn & ~deb_prev;

  // ---------------------------------------------------------------------------
  // Race FSM and datapath
  // ---------------------------------------------------------------------------
  state_t            state;
  state_t            state_nxt;
  logic [STEP_W-1:0] step_cnt;
  logic [STEP_W-1:0] step_nxt;
  logic [1:0]        cd_nxt;
  logic [2:0]        lap_nxt;
  logic [2:0]        lap_inc;
  logic [15:0]       time_nxt;
  logic              go_nxt;
  logic              cross_prev;
  logic              prev_nxt;
  logic              lap_hit;
  logic              start_pulse;
  logic              done_pulse;

  assign lap_inc = lap + 3'd1;
  assign lap_hit = frame_tick & finish_cross & ~cross_prev;

  // NOTE: every signal written here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    step_nxt    = step_cnt;
    cd_nxt      = countdown;
    lap_nxt     = lap;
    time_nxt    = race_time;
    go_nxt      = go;
    prev_nxt    = cross_prev;
    start_pulse = 1'b0;
    done_pulse  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (press) begin
          start_pulse = 1'b1;
          cd_nxt      = 2'd3;
          step_nxt    = '0;
          lap_nxt     = 3'd0;
          time_nxt    = 16'd0;
          state_nxt   = ST_COUNTDOWN;
        end
      end

      ST_COUNTDOWN: begin
        if (frame_tick) begin
          if (step_cnt == STEP_LAST) begin
            step_nxt = '0;
            if (countdown == 2'd1) begin
              cd_nxt    = 2'd0;
              go_nxt    = 1'b1;
              // Pretend the line was already occupied so a car parked on it
              // at GO has to leave and come back before scoring.
              prev_nxt  = 1'b1;
              state_nxt = ST_RACE;
            end else begin
              cd_nxt = countdown - 2'd1;
            end
          end else begin
            step_nxt = step_cnt + 1'b1;
          end
        end
      end

      ST_RACE: begin
        if (frame_tick) begin
          prev_nxt = finish_cross;
          if (lap_hit && (lap_inc == LAP_LAST)) begin
            // The final crossing freezes the clock at its pre-tick value.
            lap_nxt    = lap_inc;
            done_pulse = 1'b1;
            go_nxt     = 1'b0;
            state_nxt  = ST_DONE;
          end else begin
            if (lap_hit) begin
              lap_nxt = lap_inc;
            end
            if (race_time != TIME_MAX) begin
              time_nxt = race_time + 16'd1;
            end
          end
        end
      end

      ST_DONE: begin
        if (press) begin
          lap_nxt   = 3'd0;
          time_nxt  = 16'd0;
          cd_nxt    = 2'd0;
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state      <= ST_IDLE;
      step_cnt   <= '0;
      countdown  <= 2'd0;
      lap        <= 3'd0;
      race_time  <= 16'd0;
      go         <= 1'b0;
      cross_prev <= 1'b0;
    end else begin
      state      <= state_nxt;
      step_cnt   <= step_nxt;
      countdown  <= cd_nxt;
      lap        <= lap_nxt;
      race_time  <= time_nxt;
      go         <= go_nxt;
      cross_prev <= prev_nxt;
    end
  end

  // Pulses are masked by rst so an abort never emits a stray request or finish.
  assign start_req = start_pulse & ~rst;
  assign race_done = done_pulse & ~rst;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_race_ctrl.sv
// Self-checking bench for race_ctrl: scoreboard of expected start/finish
// pulses plus direct checks of countdown, lap, timer and reset behaviour.
module tb_race_ctrl;

  logic        pclk;
  logic        rst;
  logic        btn_start;
  logic        frame_tick;
  logic        finish_cross;
  logic        start_req;
  logic [1:0]  countdown;
  logic        go;
  logic [2:0]  lap;
  logic [15:0] race_time;
  logic        race_done;
  logic        busy;

  race_ctrl #(
    .DEB_FRAMES  (3),
    .STEP_FRAMES (60),
    .LAPS        (3)
  ) dut (
    .pclk         (pclk),
    .rst          (rst),
    .btn_start    (btn_start),
    .frame_tick   (frame_tick),
    .finish_cross (finish_cross),
    .start_req    (start_req),
    .countdown    (countdown),
    .go           (go),
    .lap          (lap),
    .race_time    (race_time),
    .race_done    (race_done),
    .busy         (busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct packed {
    logic        is_done;
    logic [15:0] rtime;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_ev;
  int  n_checks = 0;
  int  n_fail   = 0;
  logic last_pulse = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every pulse the DUT emits must match the oldest expected one.
  always @(negedge pclk) begin
    if (start_req || race_done) begin
      if (last_pulse) check("pulse_width", 32'd2, 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, start_req, race_done}, 32'd0);
      end else begin
        mon_ev = exp_q.pop_front();
        check("pulse_is_done", race_done, mon_ev.is_done);
        check("pulse_is_start", start_req, !mon_ev.is_done);
        if (mon_ev.is_done) check("done_race_time", race_time, mon_ev.rtime);
      end
    end
    last_pulse = start_req | race_done;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  // One frame = tick high for one edge, then low for one edge.
  task automatic frame(input int n);
    repeat (n) begin
      @(posedge pclk); #1 frame_tick = 1'b1;
      @(posedge pclk); #1 frame_tick = 1'b0;
    end
  endtask

  // frame_tick held high for n consecutive edges.
  task automatic hold_ticks(input int n);
    @(posedge pclk); #1 frame_tick = 1'b1;
    repeat (n) @(posedge pclk);
    #1 frame_tick = 1'b0;
  endtask

  task automatic push_start();
    exp_q.push_back('{is_done: 1'b0, rtime: 16'd0});
  endtask

  task automatic push_done(input logic [15:0] t);
    exp_q.push_back('{is_done: 1'b1, rtime: t});
  endtask

  logic [15:0] exp_time;

  initial begin
    rst          = 1'b1;
    btn_start    = 1'b0;
    frame_tick   = 1'b0;
    finish_cross = 1'b0;
    cycles(3);
    rst = 1'b0;
    cycles(1);

    check("rst_countdown", countdown, 0);
    check("rst_go", go, 0);
    check("rst_lap", lap, 0);
    check("rst_race_time", race_time, 0);
    check("rst_busy", busy, 0);
    check("rst_start_req", start_req, 0);
    check("rst_race_done", race_done, 0);

    // Glitch: high for only two frames must not register a press.
    btn_start = 1'b1;
    cycles(3);
    frame(2);
    btn_start = 1'b0;
    cycles(3);
    frame(3);
    cycles(2);
    check("glitch_busy", busy, 0);
    check("glitch_countdown", countdown, 0);

    // Real press: start_req right after the third stable frame.
    btn_start = 1'b1;
    cycles(3);
    frame(2);
    check("no_early_start", start_req, 0);
    push_start();
    frame(1);
    check("start_after_3rd", start_req, 1);
    cycles(1);
    check("start_busy", busy, 1);
    check("start_countdown", countdown, 3);
    frame(2);                      // press held 5 frames total; 2 steps counted
    btn_start    = 1'b0;
    finish_cross = 1'b1;           // car parked on the line before GO
    frame(57);
    check("cd_59_ticks", countdown, 3);
    frame(1);
    check("cd_60_ticks", countdown, 2);
    frame(59);
    check("cd_119_ticks", countdown, 2);
    frame(1);
    check("cd_120_ticks", countdown, 1);
    frame(59);
    check("cd_179_go", go, 0);
    frame(1);
    check("cd_180_countdown", countdown, 0);
    check("cd_180_go", go, 1);
    check("race_busy", busy, 1);

    // Sitting on the line for 10 frames scores nothing.
    frame(10);
    exp_time = 16'd10;
    check("parked_lap", lap, 0);
    check("parked_time", race_time, exp_time);

    for (int l = 1; l <= 3; l++) begin
      finish_cross = 1'b0;
      frame(1);
      exp_time++;
      finish_cross = 1'b1;
      if (l == 3) begin
        push_done(exp_time);
        frame(1);
      end else begin
        frame(1);
        exp_time++;
        check("lap_count", lap, l);
      end
    end
    check("done_lap", lap, 3);
    check("done_go", go, 0);
    check("done_busy", busy, 1);
    check("done_time", race_time, exp_time);
    finish_cross = 1'b0;
    frame(5);
    check("done_time_frozen", race_time, exp_time);
    check("done_lap_hold", lap, 3);

    // Press in DONE returns to IDLE without a start request.
    btn_start = 1'b1;
    cycles(3);
    frame(4);
    btn_start = 1'b0;
    cycles(3);
    frame(3);
    check("idle_busy", busy, 0);
    check("idle_lap", lap, 0);
    check("idle_time", race_time, 0);

    // Second race: tick held high, timer must saturate.
    btn_start = 1'b1;
    cycles(3);
    push_start();
    frame(3);
    cycles(1);
    btn_start = 1'b0;
    frame(3);
    hold_ticks(176);
    check("held_cd_go_early", go, 0);
    hold_ticks(1);
    check("held_go", go, 1);
    check("held_countdown", countdown, 0);
    hold_ticks(70000);
    check("sat_time", race_time, 16'hFFFF);
    check("sat_lap", lap, 0);

    finish_cross = 1'b1;
    frame(1);
    finish_cross = 1'b0;
    frame(1);
    finish_cross = 1'b1;
    frame(1);
    check("mid_lap2", lap, 2);
    finish_cross = 1'b0;
    frame(1);

    // Reset on what would be the finishing tick: no race_done.
    @(posedge pclk);
    #1;
    finish_cross = 1'b1;
    frame_tick   = 1'b1;
    rst          = 1'b1;
    @(posedge pclk);
    #1;
    frame_tick = 1'b0;
    check("abort_countdown", countdown, 0);
    check("abort_go", go, 0);
    check("abort_lap", lap, 0);
    check("abort_time", race_time, 0);
    check("abort_busy", busy, 0);
    check("abort_start_req", start_req, 0);
    check("abort_race_done", race_done, 0);
    rst          = 1'b0;
    finish_cross = 1'b0;
    cycles(3);
    check("after_abort_busy", busy, 0);
    check("pending_pulses", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
